// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle FSM that sequences the DATA_PATH via the CTRL word and memory strobes
module control_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] INSTRUCTION,
    input  logic        ZERO,
    input  logic        ready,
    output logic [31:0] CTRL,
    output logic        READ,
    output logic        WRITE
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_JMP = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c,
                           OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_PUSH = 6'h1b, OP_POP = 6'h1c,
                           OP_MULI = 6'h1d, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] FN_SLL = 6'h01, FN_SRL = 6'h02, FN_JR = 6'h08;

    typedef enum logic [4:0] {
        S_FETCH  = 5'b00001,
        S_DECODE = 5'b00010,
        S_EXE    = 5'b00100,
        S_MEM    = 5'b01000,
        S_WB     = 5'b10000
    } state_t;

    state_t      state_q, state_d;
    logic        run_q, run_d;
    logic        mem_step_q, mem_step_d;
    logic [5:0]  opcode_q, opcode_d, funct_q, funct_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic        read_q, read_d, write_q, write_d;
    logic [5:0]  dec_op, dec_fn;
    logic        take_branch;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^INSTRUCTION[25:6];

    // ALU operand selects and op; kept through MEM and WB so the result stays valid for writeback.
    function automatic logic [31:0] exe_ctrl(input logic [5:0] op, input logic [5:0] fn);
        logic [31:0] c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c[20:15] = fn;
                if (fn == FN_SLL || fn == FN_SRL) begin
                    c[13] = 1'b1;
                    c[11] = 1'b1;
                end else begin
                    c[14] = 1'b1;
                end
            end
            OP_ADDI, OP_LW, OP_SW: begin c[20:15] = 6'h20; c[12] = 1'b1; end
            OP_MULI:               begin c[20:15] = 6'h2c; c[12] = 1'b1; end
            OP_SLTI:               begin c[20:15] = 6'h2a; c[12] = 1'b1; end
            OP_ANDI:               c[20:15] = 6'h24;
            OP_ORI:                c[20:15] = 6'h25;
            OP_BEQ, OP_BNE:        begin c[20:15] = 6'h22; c[14] = 1'b1; end
            OP_PUSH:               begin c[20:15] = 6'h22; c[10] = 1'b1; c[13] = 1'b1; end
            OP_POP:                begin c[20:15] = 6'h20; c[10] = 1'b1; c[13] = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] wb_ctrl(input logic [5:0] op, input logic [5:0] fn);
        logic [31:0] c;
        c = '0;
        c[0] = 1'b1;
        c[1] = 1'b1;
        c[3] = 1'b1;
        case (op)
            OP_RTYPE: begin
                if (fn == FN_JR) c[1] = 1'b0;
                else begin c[7] = 1'b1; c[31] = 1'b1; c[28] = 1'b1; end
            end
            OP_ADDI, OP_MULI, OP_SLTI, OP_ANDI, OP_ORI: begin
                c[7] = 1'b1; c[31] = 1'b1; c[29] = 1'b1; c[28] = 1'b1;
            end
            OP_LW:   begin c[7] = 1'b1; c[31] = 1'b1; c[29] = 1'b1; c[28] = 1'b1; c[26] = 1'b1; end
            OP_LUI:  begin c[7] = 1'b1; c[31] = 1'b1; c[29] = 1'b1; c[28] = 1'b1; c[27] = 1'b1; end
            OP_JMP:  c[3] = 1'b0;
            OP_JAL:  begin c[3] = 1'b0; c[7] = 1'b1; c[30] = 1'b1; end
            OP_POP:  begin c[7] = 1'b1; c[28] = 1'b1; c[26] = 1'b1; end
            OP_PUSH: c[9] = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d    = state_q;
        run_d      = 1'b1;
        mem_step_d = 1'b0;
        opcode_d   = opcode_q;
        funct_d    = funct_q;
        ctrl_d     = '0;
        read_d     = 1'b0;
        write_d    = 1'b0;
        if (state_q == S_DECODE) begin
            dec_op = INSTRUCTION[31:26];
            dec_fn = INSTRUCTION[5:0];
        end else begin
            dec_op = opcode_q;
            dec_fn = funct_q;
        end

        // First edge after reset release only enters FETCH; sequencing starts from there.
        if (!run_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    state_d  = S_EXE;
                    opcode_d = dec_op;
                    funct_d  = dec_fn;
                end
                S_EXE:    if (ready) state_d = S_MEM;
                S_MEM: begin
                    if (dec_op == OP_POP && !mem_step_q) mem_step_d = 1'b1;
                    else                                 state_d = S_WB;
                end
                S_WB:     state_d = S_FETCH;
                default:  state_d = S_FETCH;
            endcase
        end

        case (state_d)
            S_FETCH: begin
                ctrl_d[22] = 1'b1;
                ctrl_d[4]  = 1'b1;
                read_d     = 1'b1;
            end
            S_DECODE: ctrl_d[6] = 1'b1;
            S_EXE:    ctrl_d = exe_ctrl(dec_op, dec_fn);
            S_MEM: begin
                ctrl_d = exe_ctrl(dec_op, dec_fn);
                case (dec_op)
                    OP_LW: read_d = 1'b1;
                    OP_SW: write_d = 1'b1;
                    OP_PUSH: begin
                        write_d    = 1'b1;
                        ctrl_d[21] = 1'b1;
                        ctrl_d[23] = 1'b1;
                        ctrl_d[8]  = 1'b1;
                    end
                    OP_POP: begin
                        if (mem_step_d) begin
                            read_d     = 1'b1;
                            ctrl_d[21] = 1'b1;
                        end else begin
                            ctrl_d[9] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_WB:    ctrl_d = exe_ctrl(dec_op, dec_fn) | wb_ctrl(dec_op, dec_fn);
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_FETCH;
            run_q      <= 1'b0;
            mem_step_q <= 1'b0;
            opcode_q   <= '0;
            funct_q    <= '0;
            ctrl_q     <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            mem_step_q <= mem_step_d;
            opcode_q   <= opcode_d;
            funct_q    <= funct_d;
            ctrl_q     <= ctrl_d;
            read_q     <= read_d;
            write_q    <= write_d;
        end
    end

    // Branch decision follows ZERO live during WB so the datapath flag is used in that cycle.
    assign take_branch = (state_q == S_WB) &&
                         ((opcode_q == OP_BEQ && ZERO) || (opcode_q == OP_BNE && !ZERO));
    assign CTRL  = ctrl_q | {29'd0, take_branch, 2'd0};
    assign READ  = read_q;
    assign WRITE = write_q;
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed plus random instruction checks against a behavioural control model
module tb_control_unit;
    logic        CLK, RST, ZERO, ready;
    logic [31:0] INSTRUCTION, CTRL;
    logic        READ, WRITE;
    int          checks, errors;
    logic [31:0] pc;

    typedef enum {PH_RESET, PH_FETCH, PH_DECODE, PH_EXE, PH_MEM, PH_WB} phase_e;
    typedef enum {O2_NONE, O2_R2, O2_SHAMT, O2_ONE, O2_SEXT, O2_ZEXT} op2_e;
    typedef enum {PCS_PC1, PCS_R1, PCS_BR, PCS_JIMM} pcs_e;
    typedef enum {WA_NONE, WA_RD, WA_RT, WA_R31, WA_R0} wa_e;
    typedef enum {WD_ALU, WD_MEM, WD_LUI, WD_PC1} wd_e;

    control_unit dut (
        .CLK(CLK), .RST(RST), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO),
        .ready(ready), .CTRL(CTRL), .READ(READ), .WRITE(WRITE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction semantics first, then each decision is mapped onto its CTRL mux bits.
    function automatic logic [33:0] model(phase_e ph, logic [5:0] op, logic [5:0] fn, bit zero, bit step);
        logic [31:0] c;
        bit rd, wr, op1_sp;
        int alu;
        op2_e o2;
        pcs_e pcs;
        wa_e wa;
        wd_e wd;
        c = '0; rd = 0; wr = 0; op1_sp = 0; alu = -1;
        o2 = O2_NONE; pcs = PCS_PC1; wa = WA_NONE; wd = WD_ALU;
        if (op == 6'h00) begin
            alu = int'(fn);
            o2 = (fn == 6'h01 || fn == 6'h02) ? O2_SHAMT : O2_R2;
            if (fn == 6'h08) pcs = PCS_R1; else wa = WA_RD;
        end else begin
            case (op)
                6'h08: begin alu = 'h20; o2 = O2_SEXT; wa = WA_RT; end
                6'h1d: begin alu = 'h2c; o2 = O2_SEXT; wa = WA_RT; end
                6'h0a: begin alu = 'h2a; o2 = O2_SEXT; wa = WA_RT; end
                6'h0c: begin alu = 'h24; o2 = O2_ZEXT; wa = WA_RT; end
                6'h0d: begin alu = 'h25; o2 = O2_ZEXT; wa = WA_RT; end
                6'h23: begin alu = 'h20; o2 = O2_SEXT; wa = WA_RT; wd = WD_MEM; end
                6'h2b: begin alu = 'h20; o2 = O2_SEXT; end
                6'h04: begin alu = 'h22; o2 = O2_R2; if (zero) pcs = PCS_BR; end
                6'h05: begin alu = 'h22; o2 = O2_R2; if (!zero) pcs = PCS_BR; end
                6'h1b: begin alu = 'h22; o2 = O2_ONE; op1_sp = 1; end
                6'h1c: begin alu = 'h20; o2 = O2_ONE; op1_sp = 1; wa = WA_R0; wd = WD_MEM; end
                6'h0f: begin wa = WA_RT; wd = WD_LUI; end
                6'h02: pcs = PCS_JIMM;
                6'h03: begin pcs = PCS_JIMM; wa = WA_R31; wd = WD_PC1; end
                default: ;
            endcase
        end
        if (ph == PH_FETCH) begin
            c[22] = 1; c[4] = 1; rd = 1;
        end else if (ph == PH_DECODE) begin
            c[6] = 1;
        end else if (ph != PH_RESET) begin
            if (alu >= 0) c[20:15] = alu[5:0];
            c[10] = op1_sp;
            if (o2 == O2_R2) c[14] = 1;
            if (o2 == O2_SHAMT) begin c[13] = 1; c[11] = 1; end
            if (o2 == O2_ONE) c[13] = 1;
            if (o2 == O2_SEXT) c[12] = 1;
            if (ph == PH_MEM) begin
                if (op == 6'h23) rd = 1;
                if (op == 6'h2b) wr = 1;
                if (op == 6'h1b) begin wr = 1; c[21] = 1; c[23] = 1; c[8] = 1; end
                if (op == 6'h1c) begin
                    if (step) begin rd = 1; c[21] = 1; end else c[9] = 1;
                end
            end
            if (ph == PH_WB) begin
                c[0] = 1;
                if (pcs == PCS_PC1) begin c[3] = 1; c[1] = 1; end
                if (pcs == PCS_R1) c[3] = 1;
                if (pcs == PCS_BR) begin c[3] = 1; c[2] = 1; c[1] = 1; end
                if (pcs == PCS_JIMM) c[1] = 1;
                if (wa != WA_NONE) begin
                    c[7] = 1;
                    if (wa == WA_RD) c[31] = 1;
                    if (wa == WA_RT) begin c[31] = 1; c[29] = 1; end
                    if (wa == WA_R31) c[30] = 1;
                    if (wd == WD_ALU) c[28] = 1;
                    if (wd == WD_MEM) begin c[28] = 1; c[26] = 1; end
                    if (wd == WD_LUI) begin c[28] = 1; c[27] = 1; end
                end
                if (op == 6'h1b) c[9] = 1;
            end
        end
        return {wr, rd, c};
    endfunction

    task automatic check(input string tag, input phase_e ph, input logic [5:0] op, input logic [5:0] fn,
                         input bit zero, input bit step);
        logic [33:0] e;
        e = model(ph, op, fn, zero, step);
        checks++;
        assert (CTRL === e[31:0]) else begin
            errors++;
            $error("FAIL %s CTRL observed=%h expected=%h", tag, CTRL, e[31:0]);
        end
        checks++;
        assert (READ === e[32]) else begin
            errors++;
            $error("FAIL %s READ observed=%b expected=%b", tag, READ, e[32]);
        end
        checks++;
        assert (WRITE === e[33]) else begin
            errors++;
            $error("FAIL %s WRITE observed=%b expected=%b", tag, WRITE, e[33]);
        end
        checks++;
        assert (!(READ === 1'b1 && WRITE === 1'b1)) else begin
            errors++;
            $error("FAIL %s strobes observed=%b%b expected=not both", tag, READ, WRITE);
        end
    endtask

    task automatic run_instr(input logic [31:0] word, input int rdly, input bit zero, input bit abort_mem);
        logic [5:0]  op, fn;
        logic [31:0] r1v, br, jimm, exp_pc, dut_pc;
        op = word[31:26];
        fn = word[5:0];
        INSTRUCTION = word;
        ready = 1'($urandom); ZERO = 1'($urandom);
        @(posedge CLK); #1;
        check($sformatf("fetch_%h", word), PH_FETCH, op, fn, zero, 0);
        ready = 1'($urandom); ZERO = 1'($urandom);
        @(posedge CLK); #1;
        check($sformatf("decode_%h", word), PH_DECODE, op, fn, zero, 0);
        ready = 1'($urandom); ZERO = 1'($urandom);
        for (int k = 0; k <= rdly; k++) begin
            @(posedge CLK); #1;
            check($sformatf("exe%0d_%h", k, word), PH_EXE, op, fn, zero, 0);
            if (k == 0) INSTRUCTION = $urandom;
            ready = (k == rdly);
            ZERO = 1'($urandom);
        end
        @(posedge CLK); #1;
        check($sformatf("mem_%h", word), PH_MEM, op, fn, zero, 0);
        ready = 1'($urandom);
        if (abort_mem) begin
            #2 RST = 1'b0;
            #1 check("abort_immediate", PH_RESET, op, fn, zero, 0);
            @(posedge CLK); #1;
            check("abort_hold", PH_RESET, op, fn, zero, 0);
            @(negedge CLK);
            RST = 1'b1;
            return;
        end
        if (op == 6'h1c) begin
            @(posedge CLK); #1;
            check($sformatf("mem2_%h", word), PH_MEM, op, fn, zero, 1);
        end
        ZERO = zero;
        @(posedge CLK); #1;
        check($sformatf("wb_%h", word), PH_WB, op, fn, zero, 0);
        r1v  = $urandom;
        br   = pc + 32'd1 + {{16{word[15]}}, word[15:0]};
        jimm = {pc[31:26], word[25:0]};
        if (op == 6'h02 || op == 6'h03) exp_pc = jimm;
        else if ((op == 6'h04 && zero) || (op == 6'h05 && !zero)) exp_pc = br;
        else if (op == 6'h00 && fn == 6'h08) exp_pc = r1v;
        else exp_pc = pc + 32'd1;
        dut_pc = !CTRL[3] ? jimm : CTRL[2] ? br : CTRL[1] ? pc + 32'd1 : r1v;
        checks++;
        assert (CTRL[0] === 1'b1 && dut_pc === exp_pc) else begin
            errors++;
            $error("FAIL next_pc_%h observed=%h expected=%h", word, dut_pc, exp_pc);
        end
        pc = exp_pc;
    endtask

    initial begin
        logic [5:0] ops [17];
        logic [5:0] fns [6];
        logic [5:0] op, fn;
        logic [31:0] w;
        checks = 0; errors = 0; pc = 32'h1000;
        ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0a, 6'h0c,
                6'h0d, 6'h0f, 6'h1b, 6'h1c, 6'h1d, 6'h23, 6'h2b, 6'h3f};
        fns = '{6'h01, 6'h02, 6'h08, 6'h20, 6'h22, 6'h24};
        RST = 1'b1; ZERO = 1'b0; ready = 1'b0; INSTRUCTION = $urandom;
        #2 RST = 1'b0;
        #1 check("reset_async", PH_RESET, 6'h00, 6'h00, 0, 0);
        @(posedge CLK); #1;
        check("reset_clocked", PH_RESET, 6'h00, 6'h00, 0, 0);
        @(negedge CLK);
        RST = 1'b1;

        run_instr(32'h20221820, 0, 0, 0);
        run_instr(32'h8C220004, 3, 0, 0);
        run_instr(32'h10220003, 1, 1, 0);
        run_instr(32'h10220003, 0, 0, 0);
        run_instr(32'h0C000040, 0, 0, 0);
        run_instr(32'h6C000000, 2, 0, 0);
        run_instr(32'h70000000, 0, 0, 0);
        run_instr(32'hAC220008, 1, 0, 1);
        run_instr(32'h14220005, 0, 0, 0);
        run_instr(32'hFC000000, 0, 1, 0);

        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 16)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            w  = {op, 20'($urandom), fn};
            run_instr(w, $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
